// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned ENTRY_PC_W = 32;

  // Queue entry layout at the default 32-bit PC width; the queue itself
  // stores the same {pc, instr} packing as a flat vector.
  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead synchronous FIFO with flush; head reads as zero while empty.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop issued in the same cycle.
  assign do_pop  = pop && !flush && (count_reg != '0);
  assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch: registered fetch PC, variable-latency imem handshake,
// and an instruction queue toward decode with branch/jump redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rd,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [31:0]                instr,
  output logic [XLEN-1:0]            instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + 32;

  fetch_state_t    state_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] req_pc_reg;

  logic            push;
  logic            pop;
  logic            space;
  logic [CW:0]     occ_next;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] req_pc_inc;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head_data;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_pc_inc      = req_pc_reg + XLEN'(PC_STEP);

  assign push = (state_reg == WAIT) && imem_ack && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  // Occupancy once this cycle's push/pop land; a new request needs a free
  // slot beyond that so the queue can never overflow.
  assign occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space    = (occ_next < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_target;
          end else if (space) begin
            req_pc_reg <= fetch_pc_reg;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_target;
            state_reg    <= imem_ack ? IDLE : DISCARD;
          end else if (imem_ack) begin
            fetch_pc_reg <= req_pc_inc;
            if (space) begin
              req_pc_reg <= req_pc_inc;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DISCARD: begin
          // The squashed request must still complete before a new one issues.
          if (redirect) begin
            fetch_pc_reg <= redirect_target;
          end
          if (imem_ack) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state_reg != IDLE);
  assign imem_addr = req_pc_reg;
  assign push_data = {req_pc_reg, imem_rd};

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect),
    .head_data  (head_data),
    .head_valid (instr_valid),
    .count      (count)
  );

  assign instr_pc = head_data[EW-1:32];
  assign instr    = head_data[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, redirects,
// PC wrap and asynchronous reset in the middle of a request.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  count;

  logic auto_ack;
  logic man_ack;
  int   errors = 0;
  int   checks = 0;
  int   n_req;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count)
  );

  // Memory model: returns the address as data; zero-wait or hand-driven ack.
  assign imem_ack = auto_ack ? imem_req : man_ack;
  assign imem_rd  = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state and sequential zero-wait fetch
    step(); step();
    check("rst_req",   imem_req,    0);
    check("rst_valid", instr_valid, 0);
    check("rst_count", count,       0);
    check("rst_addr",  imem_addr,   0);
    check("rst_instr", instr,       0);
    check("rst_ipc",   instr_pc,    0);
    rst_n = 1'b1;
    step();
    check("seq_req1",  imem_req,    1);
    check("seq_addr1", imem_addr,   0);
    check("seq_val1",  instr_valid, 0);
    step();
    check("seq_val2",  instr_valid, 1);
    check("seq_ipc0",  instr_pc,    0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_ipc",   instr_pc, 64'(4 * i));
      check("seq_instr", instr,    64'(4 * i));
    end

    // Back-pressure: exactly DEPTH requests, then resume at 0x10
    instr_ready = 1'b0;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (imem_req && imem_ack) n_req++;
    end
    check("bp_nreq",  n_req,    4);
    check("bp_req",   imem_req, 0);
    check("bp_count", count,    4);
    check("bp_head",  instr_pc, 0);
    instr_ready = 1'b1;
    step();
    check("bp_resume_req",  imem_req,  1);
    check("bp_resume_addr", imem_addr, 32'h10);
    check("bp_resume_cnt",  count,     3);

    // Redirect during WAIT with 3-cycle memory latency
    auto_ack = 1'b0; man_ack = 1'b0;
    do_reset();
    step();
    check("rw_addr0", imem_addr, 0);
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("rw_hold_req",  imem_req,  1);
    check("rw_hold_addr", imem_addr, 0);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("rw_drop_req", imem_req,    0);
    check("rw_drop_val", instr_valid, 0);
    check("rw_drop_cnt", count,       0);
    step();
    check("rw_new_req",  imem_req,  1);
    check("rw_new_addr", imem_addr, 32'h100);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("rw_first_val",   instr_valid, 1);
    check("rw_first_ipc",   instr_pc,    32'h100);
    check("rw_first_instr", instr,       32'h100);

    // Redirect coincident with ACK and pop, unaligned target
    auto_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    step(); step(); step();
    check("rc_pre_cnt", count, 2);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("rc_cnt", count,       0);
    check("rc_val", instr_valid, 0);
    check("rc_req", imem_req,    0);
    step();
    check("rc_addr", imem_addr, 32'h200);
    step();
    check("rc_ipc", instr_pc, 32'h200);

    // PC wrap from 0xFFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wr_val", instr_valid, 0);
    step();
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_ipc_top",  instr_pc,  32'hFFFF_FFFC);
    check("wr_addr_nxt", imem_addr, 0);
    step();
    check("wr_ipc_zero", instr_pc, 0);
    check("wr_instr",    instr,    0);

    // Asynchronous reset between edges while a request is outstanding
    auto_ack = 1'b0; man_ack = 1'b0; instr_ready = 1'b0;
    step();
    check("ar_pre_req", imem_req,    1);
    check("ar_pre_val", instr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req",   imem_req,    0);
    check("ar_val",   instr_valid, 0);
    check("ar_count", count,       0);
    check("ar_addr",  imem_addr,   0);
    rst_n = 1'b1;
    step();
    check("ar_restart_req",  imem_req,  1);
    check("ar_restart_addr", imem_addr, 0);
    auto_ack = 1'b1; instr_ready = 1'b1;
    step();
    check("ar_first_val", instr_valid, 1);
    check("ar_first_ipc", instr_pc,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised, decoupled instruction-fetch front end for the next-generation core, replacing the single-cycle PC loop (PC register, +4 adder, branch mux, combinational instruction memory) with a registered fetch PC, a variable-latency instruction-memory handshake, and a DEPTH-entry instruction queue feeding decode. Decode applies back-pressure with valid/ready. The execute stage redirects fetch on taken branches and jumps, which flushes the queue and squashes any in-flight request.

## Interface
- XLEN, 32: address and PC width.
- DEPTH, 4: instruction queue entries. Must be a power of two and ≥2.
- RESET_PC, 0: fetch PC after reset. Bits [1:0] must be 0.
- CLK  in  1  clock. All state is updated on the rising edge.
- RST_N  in  1  reset. Asynchronous, active-low.
- IMEM_REQ  out  1  fetch request to instruction memory.
- IMEM_ADDR  out  XLEN  word-aligned fetch address.
- IMEM_ACK  in  1  memory returns IMEM_RD for the current request.
- IMEM_RD  in  32  instruction word.
- Redirect  in  1  taken branch or jump from execute.
- Redirect_PC  in  XLEN  new fetch target. Bits [1:0] are ignored and treated as 0.
- Instr  out  32  instruction at the queue head.
- Instr_PC  out  XLEN  PC of Instr.
- Instr_valid  out  1  queue is non-empty.
- Instr_ready  in  1  decode accepts the head entry.
- Count  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- **State machine** with states IDLE, WAIT and DISCARD.
  - IMEM_REQ = (state != IDLE).
  - IMEM_ADDR = req_pc, a registered copy of fetch_pc captured when the request is issued.
  - IMEM_REQ and IMEM_ADDR stay stable until IMEM_ACK.
- **Space rule.** A request may be issued only if Count plus the outstanding request count (0 or 1), after this cycle's push and pop, is less than DEPTH. The queue therefore never overflows.
- **IDLE**
  - If there is space and no Redirect: req_pc ← fetch_pc, go to WAIT.
  - If Redirect: fetch_pc ← Redirect_PC, stay in IDLE.
- **WAIT**
  - On IMEM_ACK without Redirect:
    - push {req_pc, IMEM_RD} and set fetch_pc ← req_pc+4;
    - if space remains, req_pc ← req_pc+4 and stay in WAIT (back-to-back);
    - otherwise go to IDLE.
  - On Redirect with no ACK: flush the queue, fetch_pc ← Redirect_PC, go to DISCARD.
  - On Redirect together with ACK: discard the returned word, flush, fetch_pc ← Redirect_PC, go to IDLE.
- **DISCARD**
  - The request stays asserted until IMEM_ACK.
  - On ACK the data is dropped and the state goes to IDLE.
  - A further Redirect in DISCARD updates fetch_pc and the state stays DISCARD.
- **Queue**
  - Show-ahead: Instr and Instr_PC are the head entry; Instr_valid = (Count != 0).
  - A pop happens when Instr_valid && Instr_ready.
  - Push and pop in the same cycle leave Count unchanged.
  - A flush takes priority over push and pop in the same cycle. A pop requested during Redirect is void.
- **Arithmetic.** PC increment is modulo 2^XLEN: 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset (RST_N low, asynchronous):**
  - state = IDLE, fetch_pc = req_pc = RESET_PC;
  - queue empty, Count = 0, Instr_valid = 0;
  - IMEM_REQ = 0, IMEM_ADDR = RESET_PC;
  - Instr and Instr_PC = 0.
- **After reset release:**
  - IMEM_REQ rises on the first clock edge after RST_N is sampled high.
  - The first request address is RESET_PC.
- **Latency.** IMEM_ACK in cycle n gives Instr_valid in cycle n+1, with that word at the queue head if the queue was empty.
- **Throughput.** With ACK in every WAIT cycle the unit sustains 1 instruction/cycle until the queue is full.
- **Redirect.**
  - Redirect asserted in cycle n gives Instr_valid = 0 in cycle n+1.
  - The first request to Redirect_PC is issued no earlier than cycle n+2, or 2 cycles after the DISCARD ACK.
- **Reset mid-request.** The unit abandons the outstanding request immediately. The memory is required to drop it.

## Structure
- **Package fetch_pkg:**
  - fetch_state_t enum (IDLE, WAIT, DISCARD);
  - the queue entry struct {pc, instr};
  - the PC_STEP = 4 constant.
- **One sub-module, fetch_queue:**
  - synchronous FIFO with parameters WIDTH and DEPTH;
  - ports push, pop and flush, show-ahead output, and count;
  - the same CLK/RST_N conventions.
- The FSM, PC registers and the space rule live in fetch_unit.

## Test plan
- **Reset and sequential fetch.** Reset, zero-wait memory returning IMEM_RD = address, Instr_ready = 1.
  - Instr_PC = 0x0, 0x4, 0x8… on consecutive cycles.
  - Instr = Instr_PC.
- **Back-pressure.** DEPTH = 4, Instr_ready = 0.
  - Exactly 4 requests are issued, then IMEM_REQ = 0 and Count = 4.
  - Asserting ready resumes fetch at 0x10.
- **Redirect during WAIT.** Memory latency 3 cycles, Redirect to 0x100 one cycle after the request.
  - The stale word is dropped.
  - The next issued IMEM_ADDR is 0x100 and Instr_PC = 0x100 is delivered first.
- **Redirect coincident with ACK and pop.** Redirect_PC = 0x203.
  - The returned word and the popped entry are discarded.
  - Count = 0 next cycle.
  - Fetch restarts at 0x200.
- **PC wrap.** Redirect to 0xFFFF_FFFC.
  - The following Instr_PC is 0x0000_0000.
- **Asynchronous reset mid-request.** RST_N pulsed low between edges while in WAIT.
  - IMEM_REQ and Instr_valid go to 0 immediately.
  - Fetch restarts at RESET_PC.
